mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch (IF) port and data-memory (MEM-stage) port.
- Serialises accesses using a req/gnt/valid handshake and sequences a fixed-latency memory access.
- Returns read data to the correct requester and raises stall outputs that the pipeline uses to freeze the PC and pipe registers.
- Sits between the CPU core and the memory model, replacing the separate instruction/data memories.

Parameters:
- LAT, 2, memory access cycles per transaction (legal range 1..15).
- STARVE_MAX, 4, consecutive data grants allowed while a fetch waits (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- if_req  in  1  fetch request.
- if_addr  in  64  fetch byte address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_valid  out  1  fetch data valid pulse.
- if_rdata  out  32  instruction word (mem_rdata[31:0]).
- dm_req  in  1  data request.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  64  data byte address.
- dm_wdata  in  64  store data.
- dm_size  in  4  transfer size in bytes (1/2/4/8).
- dm_gnt  out  1  data request accepted this cycle.
- dm_valid  out  1  load data valid / store acknowledge pulse.
- dm_rdata  out  64  load data; 0 for stores.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write enable.
- mem_addr  out  64  latched address.
- mem_wdata  out  64  latched store data.
- mem_size  out  4  latched size.
- mem_rdata  in  64  memory read data, valid in the last ACCESS cycle.
- stall_if  out  1  fetch pending and not completed.
- stall_mem  out  1  data access pending and not completed.

Behaviour:
- Reset (async, immediate), all outputs 0:
  - state = IDLE; owner = NONE; counters = 0.
  - An in-flight access is abandoned; no valid pulse is produced.
- States: IDLE, ACCESS.
- IDLE:
  - If any req is high: grant combinationally in the same cycle (exactly one gnt), latch addr/we/wdata/size/owner, go to ACCESS, cnt = LAT-1.
  - Otherwise stay in IDLE.
- ACCESS:
  - mem_en = 1; mem_we = latched we AND owner == DM.
  - Outputs are held stable for LAT cycles.
  - cnt decrements; when cnt == 0, register mem_rdata into the owner's rdata and go to IDLE.
- Response timing: valid pulses for exactly one cycle, the cycle after the last ACCESS cycle (coincident with IDLE).
  - A new grant may occur in that same cycle.
  - Request-to-valid latency is LAT+1 cycles when the port is idle; peak throughput is one access per LAT+1 cycles.
- Priority:
  - dm_req beats if_req, because the MEM stage is older.
  - Simultaneous requests: dm is granted and if waits.
- Requester rules:
  - Hold req and all request fields stable until gnt.
  - May deassert the cycle after gnt.
  - req held after valid is treated as a new request.
- rdata holds its last value between pulses.
- IF stores are impossible: mem_we is forced 0 when owner == IF.
- stall_x = x_req AND NOT x_valid, evaluated combinationally each cycle.
- The arbiter never reorders: there is at most one transaction outstanding.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit starve counter increments on each dm grant while if_req is high.
  - It clears on any if grant or when if_req is low.
  - When the counter reaches STARVE_MAX, if wins the next arbitration even if dm_req is high.
- Undefined: strict dm priority; the counter logic is absent.

Decomposition:
- Package mem_arb_pkg:
  - owner_t enum {OWN_NONE, OWN_IF, OWN_DM}.
  - state_t enum {S_IDLE, S_ACCESS}.
  - Size constants SZ_B = 1, SZ_H = 2, SZ_W = 4, SZ_D = 8.
  - Default LAT/STARVE_MAX localparams.
- One sub-module, mem_arb_counter: loadable down-counter with a zero flag, async reset, reused for both the latency count and (inverted use) the starve count.

Test Plan:
- Lone fetch, LAT=2: if_req=1, if_addr=0x40 at cycle 0.
  - Expect if_gnt at cycle 0 and mem_en at cycles 1–2 with mem_addr=0x40.
  - Expect if_valid at cycle 3 with if_rdata = mem_rdata[31:0] sampled at cycle 2.
  - stall_if is 1 at cycles 0–2 and 0 at cycle 3.
- Simultaneous: if_req=1 (0x10) and dm_req=1 load (0x800) at cycle 0.
  - dm_gnt at cycle 0, dm_valid at cycle 3.
  - if_gnt at cycle 3, if_valid at cycle 6.
- Store: dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, size=8.
  - mem_we=1 for 2 cycles with those values.
  - dm_valid pulses with dm_rdata=0.
- Reset mid-ACCESS (assert at cycle 1 of a fetch).
  - mem_en drops in the same cycle.
  - No if_valid afterwards.
  - After release, a new fetch completes normally.
- Guard (MEM_ARB_STARVE_GUARD_EN, STARVE_MAX=4): dm_req and if_req held high continuously.
  - Grant sequence is dm,dm,dm,dm,if,dm…
  - Without the macro, only dm grants occur.
- Back-to-back fetches, LAT=1: if_req held high.
  - if_gnt every 2 cycles.
  - if_valid coincides with the next if_gnt.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    localparam logic [3:0] SZ_B = 4'd1;
    localparam logic [3:0] SZ_H = 4'd2;
    localparam logic [3:0] SZ_W = 4'd4;
    localparam logic [3:0] SZ_D = 4'd8;

    localparam int unsigned LAT_DEF        = 2;
    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned CNT_W          = 4;

    function automatic logic is_legal_size(input logic [3:0] sz);
        return (sz == SZ_B) || (sz == SZ_H) || (sz == SZ_W) || (sz == SZ_D);
    endfunction

endpackage

// File: rtl/mem_arb_counter.sv
// Loadable saturating down-counter with a zero flag; used for the access
// latency and, counting down a remaining allowance, for fetch starvation.
module mem_arb_counter #(
    parameter int unsigned   W       = 4,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= RST_VAL;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Optional fetch-starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LAT        = LAT_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_wdata,
    input  logic [3:0]  dm_size,
    output logic        dm_gnt,
    output logic        dm_valid,
    output logic [63:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [3:0]  mem_size,
    input  logic [63:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem
);

    state_t      state, state_nxt;
    owner_t      owner;
    logic        we_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [3:0]  size_q;
    logic        grant_if, grant_dm, done;
    logic        lat_zero;
    logic        if_win;
    logic        if_valid_q, dm_valid_q;
    logic [31:0] if_rdata_q;
    logic [63:0] dm_rdata_q;

    mem_arb_counter #(.W(CNT_W)) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (grant_if | grant_dm),
        .load_val (CNT_W'(LAT - 1)),
        .dec      (state == S_ACCESS),
        .zero     (lat_zero)
    );

`ifdef MEM_ARB_STARVE_GUARD_EN
    // Counts down the data grants still allowed while a fetch is waiting.
    logic starve_zero;

    mem_arb_counter #(.W(CNT_W), .RST_VAL(CNT_W'(STARVE_MAX))) u_starve_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (grant_if | ~if_req),
        .load_val (CNT_W'(STARVE_MAX)),
        .dec      (grant_dm & if_req),
        .zero     (starve_zero)
    );

    assign if_win = starve_zero & if_req;
`else
    assign if_win = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_dm  = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!reset && (if_req || dm_req)) begin
                    if (dm_req && !if_win)
                        grant_dm = 1'b1;
                    else
                        grant_if = 1'b1;
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (lat_zero) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request fields are captured at grant so the requester may move on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner   <= OWN_NONE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
        end else if (grant_dm) begin
            owner   <= OWN_DM;
            we_q    <= dm_we;
            addr_q  <= dm_addr;
            wdata_q <= dm_wdata;
            size_q  <= dm_size;
        end else if (grant_if) begin
            owner   <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= if_addr;
            wdata_q <= '0;
            size_q  <= SZ_W;
        end else if (done) begin
            owner   <= OWN_NONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if_valid_q <= done && (owner == OWN_IF);
            dm_valid_q <= done && (owner == OWN_DM);
            if (done && (owner == OWN_IF))
                if_rdata_q <= mem_rdata[31:0];
            if (done && (owner == OWN_DM))
                dm_rdata_q <= we_q ? 64'd0 : mem_rdata;
        end
    end

    assign if_gnt    = grant_if;
    assign dm_gnt    = grant_dm;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

    assign mem_en    = (state == S_ACCESS);
    assign mem_we    = mem_en & we_q & (owner == OWN_DM);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_size  = size_q;

    assign stall_if  = ~reset & if_req & ~if_valid_q;
    assign stall_mem = ~reset & dm_req & ~dm_valid_q;

endmodule
